addr_gen_2d: RTL
================

ADDR_GEN_2D -- requirements
Module: addr_gen_2d

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address and pitch width in bits.
REQ-002 The block SHALL have parameter DIM_W, default 16, meaning width, length and counter width in bits.
REQ-003 The block SHALL have port HCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: pulse that latches the configuration and begins a frame.
REQ-006 The block SHALL have port abort, input, 1 bit: terminates the frame.
REQ-007 The block SHALL have port advance, input, 1 bit: the current address was consumed; step to the next element.
REQ-008 The block SHALL have port base_addr, input, ADDR_W bits: frame start byte address.
REQ-009 The block SHALL have port width, input, DIM_W bits: elements per row.
REQ-010 The block SHALL have port length, input, DIM_W bits: rows per frame.
REQ-011 The block SHALL have port pitch, input, ADDR_W bits: row stride in bytes; 0 means packed.
REQ-012 The block SHALL have port step_mode, input, 2 bits: element size, 00=1 B, 01=2 B, 10=4 B, 11 reserved and treated as 4 B.
REQ-013 The block SHALL have port curr_addr, output, ADDR_W bits: byte address of the current element.
REQ-014 The block SHALL have port col, output, DIM_W bits: current column index.
REQ-015 The block SHALL have port row, output, DIM_W bits: current row index.
REQ-016 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-017 The block SHALL have port last, output, 1 bit: current element is the final one of the frame.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-019 The block SHALL implement states IDLE, RUN and DONE.
REQ-020 In IDLE with start=1, the block SHALL latch base_addr, width, length, pitch and step_mode, clear col, row and offsets, and enter RUN the next cycle; if width=0 or length=0 it SHALL enter DONE instead.
REQ-021 start SHALL be ignored in RUN and DONE; advance SHALL be ignored in IDLE and DONE.
REQ-022 curr_addr SHALL be combinational from registers: base + row_off + col_off, modulo 2^ADDR_W; wrap-around is silent.
REQ-023 The element step SHALL be 1, 2 or 4 B per step_mode; the effective pitch SHALL be width*step when pitch=0, else pitch.
REQ-024 On advance in RUN with col<width-1, col SHALL increment by 1 and col_off by step.
REQ-025 On advance in RUN with col=width-1 and row<length-1, col and col_off SHALL clear, row SHALL increment, and row_off SHALL increase by the effective pitch.
REQ-026 On advance with last=1, the block SHALL go to DONE; curr_addr, col and row SHALL hold their final values.
REQ-027 last SHALL be high only in RUN when col=width-1 and row=length-1.
REQ-028 DONE SHALL last exactly one cycle with done=1, then go to IDLE; col, row and offsets SHALL keep their final values until the next start.
REQ-029 abort in RUN SHALL go to DONE the next cycle, with priority over advance in the same cycle; abort in IDLE or DONE SHALL have no effect.
REQ-030 Latency SHALL be 1 cycle from start to busy=1 and 1 cycle from advance to updated curr_addr.

Reset
REQ-031 On HRESET=1 at a rising HCLK edge, the block SHALL enter IDLE and clear every register: curr_addr=base(0)+0=0, col=0, row=0, busy=0, last=0, done=0.
REQ-032 HRESET SHALL override start, abort and advance in the same cycle, including mid-frame; no done pulse SHALL be emitted for a frame killed by reset.

Structure
REQ-033 Package addr_gen_pkg SHALL hold the state_t enum (IDLE, RUN, DONE), the step_mode_t enum and a function mapping step_mode to a byte step.
REQ-034 A single sub-module, wrap_counter (DIM_W-bit counter with enable, clear and terminal-count output), SHALL be instantiated twice, for col and row.

Verification
REQ-035 base=0x1000, width=3, length=2, pitch=0, mode=4 B, advance every cycle -> curr_addr 0x1000, 0x1004, 0x1008, 0x100C, 0x1010, 0x1014; last on the sixth; done pulses once.
REQ-036 base=0x2000, width=2, length=3, pitch=0x100, mode=1 B -> addresses 0x2000, 0x2001, 0x2100, 0x2101, 0x2200, 0x2201.
REQ-037 width=0, length=5, start -> no busy; done=1 exactly in the second cycle after start.
REQ-038 Abort and advance asserted together at row=1, col=0 -> done next cycle, row and col hold at 1 and 0.
REQ-039 HRESET mid-frame at row=1 -> the next cycle shows IDLE, all outputs 0, no done pulse; a following start runs normally.
REQ-040 base=0xFFFFFFFC, width=2, length=1, mode=4 B -> addresses 0xFFFFFFFC, 0x00000000 (wrap); start pulsed during RUN is ignored.

Source files
------------

// File: rtl/addr_gen_pkg.sv
// Shared types for the 2-D address generator: FSM states, element-size codes
// and the mapping from element-size code to byte step.
package addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_1B   = 2'b00,
    STEP_2B   = 2'b01,
    STEP_4B   = 2'b10,
    STEP_RSVD = 2'b11
  } step_mode_t;

  // The reserved code behaves like the 4-byte element size.
  function automatic logic [2:0] step_bytes(input step_mode_t mode);
    case (mode)
      STEP_1B: return 3'd1;
      STEP_2B: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Index counter that clears, counts on enable, and wraps to zero after its
// terminal value; tc flags that the count sits on the terminal value.
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == max);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/addr_gen_2d.sv
// Row/column address generator: walks a width x length frame of 1/2/4-byte
// elements starting at base_addr, with a configurable row stride.
//
// state | meaning
// IDLE  | waiting for start; counters and offsets keep the last frame's values
// RUN   | presenting curr_addr, stepping on advance
// DONE  | one-cycle done pulse, then back to IDLE
module addr_gen_2d
  import addr_gen_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              abort,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  length,
  input  logic [ADDR_W-1:0] pitch,
  input  logic [1:0]        step_mode,
  output logic [ADDR_W-1:0] curr_addr,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic              busy,
  output logic              last,
  output logic              done
);

  state_t            state;
  step_mode_t        mode_q;
  logic [ADDR_W-1:0] base_q, pitch_q, row_off, col_off;
  logic [DIM_W-1:0]  width_q, length_q, col_max, row_max;
  logic [ADDR_W-1:0] step, eff_pitch;
  logic              launch, stepping, col_tc, row_tc;

  assign launch    = (state == IDLE) && start;
  assign stepping  = (state == RUN) && advance && !abort && !last;
  assign step      = ADDR_W'(step_bytes(mode_q));
  assign eff_pitch = (pitch_q == '0) ? ADDR_W'(width_q) * step : pitch_q;
  assign col_max   = width_q - DIM_W'(1);
  assign row_max   = length_q - DIM_W'(1);
  assign last      = (state == RUN) && col_tc && row_tc;
  assign curr_addr = base_q + row_off + col_off;

  wrap_counter #(.W(DIM_W)) u_col (
    .clk   (HCLK),
    .rst   (HRESET),
    .clr   (launch),
    .en    (stepping),
    .max   (col_max),
    .count (col),
    .tc    (col_tc)
  );

  wrap_counter #(.W(DIM_W)) u_row (
    .clk   (HCLK),
    .rst   (HRESET),
    .clr   (launch),
    .en    (stepping && col_tc),
    .max   (row_max),
    .count (row),
    .tc    (row_tc)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      base_q   <= '0;
      pitch_q  <= '0;
      width_q  <= '0;
      length_q <= '0;
      mode_q   <= STEP_1B;
      row_off  <= '0;
      col_off  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            pitch_q  <= pitch;
            width_q  <= width;
            length_q <= length;
            mode_q   <= step_mode_t'(step_mode);
            row_off  <= '0;
            col_off  <= '0;
            // An empty frame still produces its done pulse.
            if (width == '0 || length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort || (advance && last)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (advance) begin
            if (col_tc) begin
              col_off <= '0;
              row_off <= row_off + eff_pitch;
            end else begin
              col_off <= col_off + step;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
